// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit memory request/response, redirect and ID delivery bundle
interface fetch_unit_if;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;

  modport master (
    output req_valid_o, req_addr_o, id_valid_o, id_pc_o, id_instr_o,
    input  req_ready_i, rsp_valid_i, rsp_data_i, redirect_i, redirect_pc_i, id_ready_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, id_valid_o, id_pc_o, id_instr_o,
    output req_ready_i, rsp_valid_i, rsp_data_i, redirect_i, redirect_pc_i, id_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF1/IF2 fetch front end: PC generation, credit-bounded reads, {pc,instr} buffer to ID
// Optional macro FETCH_BYPASS_EN adds a same-cycle response-to-ID path when the buffer is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   rsp_pc_q;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [31:0]   pc_mem    [FIFO_DEPTH];
  logic [31:0]   instr_mem [FIFO_DEPTH];

  logic [CW:0]   credit_sum;
  logic [CW:0]   drop_sum;
  logic [CW:0]   live_w;
  logic          req_fire;
  logic          rsp_keep;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic [CW-1:0] inflight_nxt;
  logic [CW-1:0] drop_nxt;
  logic [CW-1:0] count_nxt;
  logic [31:0]   redirect_pc;
  logic [31:0]   head_pc;
  logic [31:0]   head_instr;
  wire           unused_redirect_lsb = ^bus.redirect_pc_i[1:0];

  assign redirect_pc = {bus.redirect_pc_i[31:2], 2'b00};
  assign credit_sum  = {1'b0, inflight_q} + {1'b0, count_q};
  assign fifo_empty  = (count_q == '0);

  // Credits cover both in-flight and buffered entries, so every response has a slot.
  assign bus.req_valid_o = !rst_i && !bus.redirect_i && (credit_sum < DEPTH_C);
  assign bus.req_addr_o  = pc_q;
  assign req_fire        = bus.req_valid_o && bus.req_ready_i;

  assign rsp_keep = bus.rsp_valid_i && !bus.redirect_i && (drop_q == '0);
  assign pop      = !fifo_empty && bus.id_ready_i && !bus.redirect_i;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass     = rsp_keep && fifo_empty;
  assign push       = rsp_keep && !(bypass && bus.id_ready_i);
  assign head_valid = !fifo_empty || bypass;
  assign head_pc    = bypass ? rsp_pc_q       : pc_mem[rd_ptr_q];
  assign head_instr = bypass ? bus.rsp_data_i : instr_mem[rd_ptr_q];
`else
  assign push       = rsp_keep;
  assign head_valid = !fifo_empty;
  assign head_pc    = pc_mem[rd_ptr_q];
  assign head_instr = instr_mem[rd_ptr_q];
`endif

  assign bus.id_valid_o = !rst_i && head_valid;
  assign bus.id_pc_o    = bus.id_valid_o ? head_pc    : '0;
  assign bus.id_instr_o = bus.id_valid_o ? head_instr : '0;

  always_comb begin
    inflight_nxt = inflight_q + CW'(req_fire) - CW'(bus.rsp_valid_i);
    live_w       = {1'b0, inflight_q} - (CW+1)'(bus.rsp_valid_i);
    drop_sum     = {1'b0, drop_q} + {1'b0, inflight_q} - (CW+1)'(bus.rsp_valid_i);
    drop_nxt     = drop_q;
    count_nxt    = count_q;
    if (bus.redirect_i) begin
      // Everything still outstanding belongs to the old path; never drop more than is live.
      drop_nxt  = (drop_sum > live_w) ? live_w[CW-1:0] : drop_sum[CW-1:0];
      count_nxt = '0;
    end else begin
      if (bus.rsp_valid_i && (drop_q != '0)) begin
        drop_nxt = drop_q - CW'(1);
      end
      case ({push, pop})
        2'b10:   count_nxt = count_q + CW'(1);
        2'b01:   count_nxt = count_q - CW'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_nxt;
      drop_q     <= drop_nxt;
      count_q    <= count_nxt;
      if (bus.redirect_i) begin
        pc_q     <= redirect_pc;
        rsp_pc_q <= redirect_pc;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (req_fire) begin
          pc_q <= pc_q + 32'd4;
        end
        // Kept responses arrive in request order, so their PC simply counts up from the last restart.
        if (rsp_keep) begin
          rsp_pc_q <= rsp_pc_q + 32'd4;
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= rsp_pc_q;
      instr_mem[wr_ptr_q] <= bus.rsp_data_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a budgeted, fixed-latency memory model
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] XOR_K  = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct { int due; logic [31:0] addr; } pend_t;
  pend_t       pend_q[$];
  logic [63:0] exp_q[$];
  int passed = 0, total = 0;
  int cycle = 0, budget = 0, lat = 1, acc_count = 0;
  int first_dlv = -1, last_dlv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    logic [31:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({p, p ^ XOR_K});
      p = p + 32'd4;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    total++;
    if (exp_q.size() != 0) $display("FAIL drain_%s: %0d deliveries outstanding, required 0", name, exp_q.size());
    else passed++;
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Memory: accepts while budget lasts, answers in order after lat cycles with addr ^ XOR_K.
  initial begin
    bus.req_ready_i = 1'b0;
    bus.rsp_valid_i = 1'b0;
    bus.rsp_data_i  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.req_valid_o && bus.req_ready_i) begin
        pend_q.push_back('{cycle + lat, bus.req_addr_o});
        acc_count++;
        budget--;
      end
      @(posedge clk);
      #1;
      bus.rsp_valid_i = 1'b0;
      bus.rsp_data_i  = '0;
      if (rst) pend_q.delete();
      else if (pend_q.size() > 0 && pend_q[0].due <= cycle) begin
        bus.rsp_valid_i = 1'b1;
        bus.rsp_data_i  = pend_q[0].addr ^ XOR_K;
        void'(pend_q.pop_front());
      end
      bus.req_ready_i = !rst && (budget > 0);
    end
  end

  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.id_valid_o && bus.id_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_delivery: got pc %h, required no delivery", bus.id_pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("delivery_pc", bus.id_pc_o, e[63:32]);
          chk("delivery_instr", bus.id_instr_o, e[31:0]);
        end
        if (first_dlv < 0) first_dlv = cycle;
        last_dlv = cycle;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0;
    logic bypass_exp;
`ifdef FETCH_BYPASS_EN
    bypass_exp = 1'b1;
`else
    bypass_exp = 1'b0;
`endif
    bus.id_ready_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    repeat (3) step();
    chk("rst_req_valid", {31'd0, bus.req_valid_o}, 32'd0);
    chk("rst_req_addr", bus.req_addr_o, RST_PC);
    chk("rst_id_valid", {31'd0, bus.id_valid_o}, 32'd0);
    chk("rst_id_pc", bus.id_pc_o, 32'd0);
    chk("rst_id_instr", bus.id_instr_o, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_req_valid", {31'd0, bus.req_valid_o}, 32'd1);
    chk("first_req_addr", bus.req_addr_o, RST_PC);

    // Streaming from RESET_PC, including the 32-bit address wrap.
    budget = 8;
    bus.id_ready_i = 1'b1;
    expect_seq(RST_PC, 8);
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rsp_valid_i) break;
    end
    #1;
    chk("rsp_to_id_latency", {31'd0, bus.id_valid_o}, {31'd0, bypass_exp});
    step();
    chk("id_valid_after_rsp", {31'd0, bus.id_valid_o}, 32'd1);
    wait_drain("stream");
    chk("stream_throughput", last_dlv - first_dlv, 32'd7);

    // ID stall: credits stop requests at FIFO_DEPTH.
    a0 = acc_count;
    bus.id_ready_i = 1'b0;
    budget = 6;
    repeat (12) step();
    chk("stall_accepted", acc_count - a0, 32'd4);
    chk("stall_req_valid", {31'd0, bus.req_valid_o}, 32'd0);
    chk("stall_id_valid", {31'd0, bus.id_valid_o}, 32'd1);
    expect_seq(32'h0000_0018, 6);
    bus.id_ready_i = 1'b1;
    wait_drain("stall");
    chk("resume_accepted", acc_count - a0, 32'd6);

    // Redirect with two requests in flight.
    lat = 3;
    budget = 2;
    a0 = acc_count;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc_count - a0 >= 2) break;
    end
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_1002;
    budget = 3;
    lat = 1;
    expect_seq(32'h0000_1000, 3);
    #1;
    chk("redirect_no_req", {31'd0, bus.req_valid_o}, 32'd0);
    step();
    bus.redirect_i = 1'b0;
    #1;
    chk("redirect_req_addr", bus.req_addr_o, 32'h0000_1000);
    chk("redirect_req_valid", {31'd0, bus.req_valid_o}, 32'd1);
    wait_drain("redirect");

    // Back-to-back redirects, the first one coinciding with a response.
    lat = 2;
    budget = 2;
    a0 = acc_count;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc_count - a0 >= 2) break;
    end
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_2000;
    step();
    bus.redirect_pc_i = 32'h0000_3000;
    lat = 1;
    budget = 2;
    expect_seq(32'h0000_3000, 2);
    step();
    bus.redirect_i = 1'b0;
    #1;
    chk("b2b_req_addr", bus.req_addr_o, 32'h0000_3000);
    wait_drain("b2b_redirect");

    // Asynchronous reset with three buffered entries.
    bus.id_ready_i = 1'b0;
    budget = 3;
    repeat (8) step();
    chk("prereset_id_valid", {31'd0, bus.id_valid_o}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_id_valid", {31'd0, bus.id_valid_o}, 32'd0);
    chk("midrst_req_valid", {31'd0, bus.req_valid_o}, 32'd0);
    chk("midrst_id_pc", bus.id_pc_o, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("restart_req_addr", bus.req_addr_o, RST_PC);
    budget = 2;
    bus.id_ready_i = 1'b1;
    expect_seq(RST_PC, 2);
    wait_drain("restart");
    repeat (10) step();
    chk("no_stray_expected", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end of the 7-stage core: covers IF1 (PC generation and memory read request) and IF2 (response capture and buffering). Delivers `{pc, instr}` pairs to the ID stage over a valid/ready handshake. Accepts redirects (branch, jump, exception) from later stages, and discards responses to requests made on the wrong path. Bounds in-flight requests so that every accepted response has guaranteed buffer space.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 4: fetch buffer entries; power of two, ≥2; also the maximum in-flight plus buffered count.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; one clock, asynchronous, active-high.
- `req_valid_o`  out  1  read request valid (IF1).
- `req_ready_i`  in  1  memory accepts the request this cycle.
- `req_addr_o`  out  32  fetch address, word aligned.
- `rsp_valid_i`  in  1  read data valid; in order, at most one per cycle, never in the same cycle as its request's acceptance.
- `rsp_data_i`  in  32  instruction word.
- `redirect_i`  in  1  flush the pipeline and restart fetch.
- `redirect_pc_i`  in  32  new PC; bits [1:0] ignored and treated as 0.
- `id_valid_o`  out  1  instruction available to ID.
- `id_ready_i`  in  1  ID consumes this cycle.
- `id_pc_o`  out  32  PC of the presented instruction.
- `id_instr_o`  out  32  presented instruction word.

## Operation
- State:
  - `pc_q` (next address to request).
  - `inflight_q` (accepted requests not yet answered, width clog2(FIFO_DEPTH+1)).
  - `drop_q` (responses still to discard, same width).
  - Circular FIFO of `{pc, instr}` with read/write pointers and count.
  - FIFO of request PCs, or equivalently the PC tagged at issue, so each response is paired with its address.
- Request issue:
  - `req_valid_o = !rst_i && !redirect_i && (inflight_q + fifo_count < FIFO_DEPTH)`.
  - `req_addr_o = pc_q`.
  - On `req_valid_o && req_ready_i`: `pc_q <= pc_q + 4`, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000), and `inflight_q` increments.
- Response:
  - Every `rsp_valid_i` decrements `inflight_q`.
  - If `drop_q != 0`, the response is discarded and `drop_q` decrements.
  - Otherwise `{pc, rsp_data_i}` is written to the FIFO. By construction the FIFO is never full when a response arrives; a response arriving with the FIFO full is a protocol error and is not handled.
- Delivery:
  - `id_valid_o` = FIFO not empty.
  - `id_pc_o` and `id_instr_o` = FIFO head.
  - Pop on `id_valid_o && id_ready_i`.
  - Simultaneous push and pop leaves the count unchanged.
- Redirect (highest priority), in the cycle `redirect_i` is high:
  - No request is issued.
  - FIFO is cleared (an ID pop in that cycle is ignored).
  - A response in that cycle is dropped.
  - `drop_q <= drop_q + inflight_q - rsp_valid_i`, clamped to the live in-flight count.
  - `pc_q <= {redirect_pc_i[31:2], 2'b00}`.
  - Back-to-back redirects: the last one wins; drop accounting stays exact.
- Reset, including mid-operation, applies immediately and asynchronously:
  - `pc_q = RESET_PC`; `inflight_q`, `drop_q`, FIFO count and pointers = 0.
  - `req_valid_o = 0`, `req_addr_o = RESET_PC`.
  - `id_valid_o = 0`, `id_pc_o = 0`, `id_instr_o = 0`.
  - The memory is required to be reset together with this block; stale responses after reset are not tolerated.

## Timing
- First request: `req_valid_o` = 1 with address `RESET_PC` in the first cycle after `rst_i` deasserts.
- Request throughput: one request per cycle while credits remain.
- Response-to-ID latency: response in cycle N gives `id_valid_o` in cycle N+1 (registered FIFO, no bypass by default).
- Redirect: new PC presented on `req_addr_o` in cycle R+1 for a redirect in cycle R. First ID-visible instruction from the new path is no earlier than R+3 with one-cycle memory latency.
- With a single-cycle memory and ID always ready, sustained throughput is one instruction per cycle when `FIFO_DEPTH` ≥ 2.

## Configuration
- `FETCH_BYPASS_EN`:
  - Defined: when the FIFO is empty, `drop_q == 0`, no redirect and `rsp_valid_i` = 1, the response is presented on `id_*_o` combinationally in the same cycle. It is not written to the FIFO if `id_ready_i` = 1, and is written otherwise. Response-to-ID latency becomes 0.
  - Undefined: pure registered path, latency 1; no combinational path from `rsp_*` to `id_*`.

## Test plan
- Reset release, `req_ready_i` = 1, memory returns `instr = addr ^ 0xA5A5_A5A5` one cycle later, ID ready → ID receives PC 0x0, 0x4, 0x8, … with matching data, one per cycle after the initial latency.
- ID stalled (`id_ready_i` = 0) with `FIFO_DEPTH` = 4 → exactly 4 requests accepted, then `req_valid_o` = 0. After ready returns, 4 instructions are delivered in order and requests resume.
- Redirect to 0x1002 with 2 requests in flight → next two `rsp_valid_i` are dropped, next `req_addr_o` = 0x1000, and the first ID instruction has PC 0x1000.
- `RESET_PC` = 0xFFFF_FFF8 → request addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- `rst_i` asserted mid-stream with FIFO holding 3 entries → `id_valid_o` and `req_valid_o` fall immediately. After release, fetch restarts at `RESET_PC` with no stale instruction delivered.
- With `FETCH_BYPASS_EN`, FIFO empty and ID ready, response 0x0000_0013 in cycle N → `id_valid_o` = 1 and `id_instr_o` = 0x0000_0013 in cycle N.
